// File: rtl/ft64_regfile_lvt.sv
// ft64_regfile_lvt: multi-port register file built from one RAM bank per
// write port, with a live-value table (LVT) that names the bank holding the
// newest copy of each register. Reads have a fixed one-cycle latency with
// write-through bypass. After reset a sweep clears bank 0 and the LVT.
//
// Interface contract (no handshake): every read port is always accepted.
// ra_k presented in cycle n yields o_k in cycle n+1, equal to the register
// value after all writes of cycle n. Writes are accepted only while busy is
// low; while busy is high they are silently dropped and every o reads 0.
module ft64_regfile_lvt #(
    parameter int WID     = 64,
    parameter int AW      = 8,
    parameter int NW      = 3,
    parameter int NR      = 12,
    parameter int ZERO_R0 = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NW-1:0]     wr,
    input  logic [NW*AW-1:0]  wa,
    input  logic [NW*WID-1:0] i,
    input  logic [NR*AW-1:0]  ra,
    output logic [NR*WID-1:0] o,
    output logic              busy,
    output logic              state_o
);

    localparam int DEPTH = 2 ** AW;
    localparam int LW    = (NW > 1) ? $clog2(NW) : 1;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   cnt_q, cnt_d;
    logic            clearing;
    logic [NW-1:0]   we_eff;

    logic [LW-1:0]   lvt_q [DEPTH];
    logic [NR*WID-1:0] bank_rd [NW];

    logic [NR-1:0]     hit_d, hit_q;
    logic [NR-1:0]     zero_d, zero_q;
    logic [NR*WID-1:0] byp_d, byp_q;
    logic [NR*LW-1:0]  sel_d, sel_q;
    logic              blank_q;

    assign clearing = (state_q == ST_CLEAR);
    assign busy     = clearing;
    assign state_o  = state_q;

    // Next-state logic: sweep every address once, then run.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_CLEAR: begin
                cnt_d = cnt_q + AW'(1);
                if (cnt_q == {AW{1'b1}}) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = state_q;
            end
        endcase
    end

    // State register with synchronous reset restarting the sweep at address 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Effective write enables: only in RUN, and r0 writes dropped when hardwired.
    always_comb begin
        we_eff = '0;
        for (int p = 0; p < NW; p++) begin
            we_eff[p] = wr[p] && !clearing && !rst &&
                        !((ZERO_R0 != 0) && (wa[p*AW +: AW] == '0));
        end
    end

    // LVT update: sweep zeroes entries; otherwise the highest enabled port wins.
    always_ff @(posedge clk) begin
        if (clearing) begin
            lvt_q[cnt_q] <= '0;
        end else begin
            for (int p = 0; p < NW; p++) begin
                if (we_eff[p]) begin
                    lvt_q[wa[p*AW +: AW]] <= LW'(p);
                end
            end
        end
    end

    for (genvar p = 0; p < NW; p++) begin : g_bank
        logic [WID-1:0]    mem [DEPTH];
        logic              bw_en;
        logic [AW-1:0]     bw_addr;
        logic [WID-1:0]    bw_data;
        logic [NR*WID-1:0] rd_q;

        // Bank write port; bank 0 is shared with the clear sweep.
        always_comb begin
            bw_en   = we_eff[p];
            bw_addr = wa[p*AW +: AW];
            bw_data = i[p*WID +: WID];
            if ((p == 0) && clearing) begin
                bw_en   = 1'b1;
                bw_addr = cnt_q;
                bw_data = '0;
            end
        end

        // Bank storage write.
        always_ff @(posedge clk) begin
            if (bw_en) begin
                mem[bw_addr] <= bw_data;
            end
        end

        // Synchronous read of this bank for every read port.
        always_ff @(posedge clk) begin
            for (int k = 0; k < NR; k++) begin
                rd_q[k*WID +: WID] <= mem[ra[k*AW +: AW]];
            end
        end

        assign bank_rd[p] = rd_q;
    end

    // Per read port: bypass match against this cycle's writes and LVT lookup.
    always_comb begin
        hit_d  = '0;
        zero_d = '0;
        byp_d  = '0;
        sel_d  = '0;
        for (int k = 0; k < NR; k++) begin
            sel_d[k*LW +: LW] = lvt_q[ra[k*AW +: AW]];
            zero_d[k] = (ZERO_R0 != 0) && (ra[k*AW +: AW] == '0);
            for (int p = 0; p < NW; p++) begin
                if (we_eff[p] && (wa[p*AW +: AW] == ra[k*AW +: AW])) begin
                    hit_d[k] = 1'b1;
                    byp_d[k*WID +: WID] = i[p*WID +: WID];
                end
            end
        end
    end

    // Read pipeline registers; blank covers reset and the whole sweep.
    always_ff @(posedge clk) begin
        blank_q <= rst || clearing;
        hit_q   <= hit_d;
        zero_q  <= zero_d;
        byp_q   <= byp_d;
        sel_q   <= sel_d;
    end

    // Output mux: zero, bypass data, or the bank named by the LVT.
    always_comb begin
        o = '0;
        for (int k = 0; k < NR; k++) begin
            if (!(blank_q || zero_q[k])) begin
                if (hit_q[k]) begin
                    o[k*WID +: WID] = byp_q[k*WID +: WID];
                end else begin
                    for (int p = 0; p < NW; p++) begin
                        if (sel_q[k*LW +: LW] == LW'(p)) begin
                            o[k*WID +: WID] = bank_rd[p][k*WID +: WID];
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ft64_regfile_lvt.sv
// Bench for ft64_regfile_lvt: two instances (r0 hardwired and not) share all
// inputs. Directed stimulus pushes hand-computed read results into a queue
// tagged with the cycle they are due; a monitor pops and compares them.
module tb_ft64_regfile_lvt;

    localparam int WID = 64;
    localparam int AW  = 8;
    localparam int NW  = 3;
    localparam int NR  = 12;

    logic              clk = 1'b0;
    logic              rst;
    logic [NW-1:0]     wr;
    logic [NW*AW-1:0]  wa;
    logic [NW*WID-1:0] wdat;
    logic [NR*AW-1:0]  ra;
    logic [NR*WID-1:0] o_z, o_nz;
    logic              busy_z, busy_nz;
    logic              st_z, st_nz;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [WID-1:0] exp_q[$];
    int             due_q[$];
    int             dut_q[$];
    int             port_q[$];
    string          name_q[$];

    ft64_regfile_lvt #(.WID(WID), .AW(AW), .NW(NW), .NR(NR), .ZERO_R0(1)) u_dut_z (
        .clk(clk), .rst(rst), .wr(wr), .wa(wa), .i(wdat), .ra(ra),
        .o(o_z), .busy(busy_z), .state_o(st_z)
    );

    ft64_regfile_lvt #(.WID(WID), .AW(AW), .NW(NW), .NR(NR), .ZERO_R0(0)) u_dut_nz (
        .clk(clk), .rst(rst), .wr(wr), .wa(wa), .i(wdat), .ra(ra),
        .o(o_nz), .busy(busy_nz), .state_o(st_nz)
    );

    // Clock and cycle counter.
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end

    // Driver tasks.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int dut, input int k, input logic [WID-1:0] v, input string nm);
        exp_q.push_back(v);
        due_q.push_back(cyc + 1);
        dut_q.push_back(dut);
        port_q.push_back(k);
        name_q.push_back(nm);
    endtask

    task automatic push_both(input int k, input logic [WID-1:0] v, input string nm);
        push(0, k, v, nm);
        push(1, k, v, nm);
    endtask

    task automatic set_ra(input int k, input logic [AW-1:0] a);
        ra[k*AW +: AW] = a;
    endtask

    task automatic set_ra_all(input logic [AW-1:0] a);
        for (int k = 0; k < NR; k++) begin
            ra[k*AW +: AW] = a;
        end
    endtask

    task automatic set_wr(input int p, input logic [AW-1:0] a, input logic [WID-1:0] d);
        wr[p] = 1'b1;
        wa[p*AW +: AW] = a;
        wdat[p*WID +: WID] = d;
    endtask

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Run through a clear sweep, counting busy cycles; a write burst to waddr
    // is attempted mid-sweep and must be discarded.
    task automatic sweep(input string nm, input logic [AW-1:0] waddr);
        int n;
        n = 0;
        while ((busy_z || busy_nz) && n < 400) begin
            if (n == 10 || n == 200) begin
                push_both(3, '0, "sweep_read_zero");
            end
            if (n == 50) begin
                set_wr(0, waddr, 64'hDEAD_0000);
                set_wr(1, waddr, 64'hDEAD_0001);
                set_wr(2, waddr, 64'hDEAD_0002);
            end else begin
                wr = '0;
            end
            n++;
            tick();
        end
        wr = '0;
        check(nm, 64'(n), 64'd256);
    endtask

    // Scoreboard monitor: compare every due expectation on the falling edge.
    initial begin : monitor
        logic [WID-1:0] act;
        int d, k, due;
        forever begin
            @(negedge clk);
            while (due_q.size() > 0 && due_q[0] <= cyc) begin
                due = due_q.pop_front();
                d   = dut_q.pop_front();
                k   = port_q.pop_front();
                act = (d == 0) ? o_z[k*WID +: WID] : o_nz[k*WID +: WID];
                checks++;
                if (due != cyc) begin
                    errors++;
                    $display("FAIL %s: dut%0d port%0d expectation missed (due %0d now %0d)",
                             name_q.pop_front(), d, k, due, cyc);
                    void'(exp_q.pop_front());
                end else if (act !== exp_q[0]) begin
                    errors++;
                    $display("FAIL %s: dut%0d port%0d got %h expected %h (cycle %0d)",
                             name_q.pop_front(), d, k, act, exp_q.pop_front(), cyc);
                end else begin
                    void'(name_q.pop_front());
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    // Directed stimulus.
    initial begin : stim
        int w;
        rst  = 1'b1;
        wr   = '0;
        wa   = '0;
        wdat = '0;
        ra   = '0;
        set_ra_all(8'd5);
        push_both(0, '0, "rst_o_zero");
        tick();
        check("busy_after_rst_z", 64'(busy_z), 64'd1);
        check("busy_after_rst_nz", 64'(busy_nz), 64'd1);
        check("state_after_rst", 64'(st_z), 64'd0);
        rst = 1'b0;

        sweep("busy_len_initial", 8'd5);
        check("state_run", 64'(st_z), 64'd1);

        // r5 after the sweep (including the discarded mid-sweep write).
        set_ra_all(8'd5);
        push_both(0, '0, "post_sweep_r5");
        push_both(11, '0, "post_sweep_r5_p11");
        tick();

        // Single write with same-cycle bypass, then bank read later.
        set_wr(0, 8'd10, 64'h1111);
        set_ra(0, 8'd10);
        push_both(0, 64'h1111, "bypass_r10");
        tick();
        wr = '0;
        set_ra(0, 8'd5);
        push_both(0, '0, "r5_between");
        tick();
        tick();
        set_ra(0, 8'd10);
        set_ra(7, 8'd10);
        push_both(0, 64'h1111, "bank_r10");
        push_both(7, 64'h1111, "bank_r10_p7");
        tick();

        // Three-way collision: port 2 wins.
        set_wr(0, 8'd20, 64'hA);
        set_wr(1, 8'd20, 64'hB);
        set_wr(2, 8'd20, 64'hC);
        set_ra_all(8'd20);
        push_both(0, 64'hC, "col3_bypass");
        push_both(11, 64'hC, "col3_bypass_p11");
        tick();
        wr = '0;
        push_both(0, 64'hC, "col3_bank");
        push_both(5, 64'hC, "col3_bank_p5");
        tick();

        // Two-way collision on ports 0,1: port 1 wins.
        set_wr(0, 8'd20, 64'hA);
        set_wr(1, 8'd20, 64'hB);
        push_both(2, 64'hB, "col01_bypass");
        tick();
        wr = '0;
        push_both(9, 64'hB, "col01_bank");
        tick();

        // Two-way collision on ports 0,2: port 2 wins.
        set_wr(0, 8'd50, 64'h55);
        set_wr(2, 8'd50, 64'h66);
        set_ra_all(8'd50);
        push_both(4, 64'h66, "col02_bypass");
        tick();
        wr = '0;
        push_both(6, 64'h66, "col02_bank");
        tick();

        // Mixed collision/non-collision on all 12 read ports.
        set_wr(0, 8'd30, 64'h1);
        set_wr(1, 8'd30, 64'h2);
        set_wr(2, 8'd31, 64'h3);
        for (int k = 0; k < NR; k++) begin
            set_ra(k, (k % 2 == 1) ? 8'd31 : 8'd30);
            push_both(k, (k % 2 == 1) ? 64'h3 : 64'h2, "split_bypass");
        end
        tick();
        wr = '0;
        for (int k = 0; k < NR; k++) begin
            push_both(k, (k % 2 == 1) ? 64'h3 : 64'h2, "split_bank");
        end
        tick();

        // Register 0: hardwired in u_dut_z, ordinary in u_dut_nz.
        set_wr(0, 8'd0, 64'hFFFF);
        set_ra_all(8'd0);
        push(0, 0, '0, "r0_z_bypass");
        push(1, 0, 64'hFFFF, "r0_nz_bypass");
        tick();
        wr = '0;
        push(0, 3, '0, "r0_z_bank");
        push(1, 3, 64'hFFFF, "r0_nz_bank");
        tick();

        // Write r40, then reset mid-sweep and check the restart.
        set_wr(0, 8'd40, 64'h55);
        set_ra_all(8'd40);
        push_both(0, 64'h55, "r40_bypass");
        tick();
        wr = '0;
        push_both(2, 64'h55, "r40_bank");
        tick();
        rst = 1'b1;
        push_both(1, '0, "rst_blank_r40");
        tick();
        rst = 1'b0;
        for (int n = 0; n < 100; n++) begin
            tick();
        end
        check("busy_mid_sweep", 64'(busy_z), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sweep("busy_len_restart", 8'd40);

        set_ra_all(8'd40);
        push_both(0, '0, "r40_cleared");
        push_both(11, '0, "r40_cleared_p11");
        tick();
        set_ra_all(8'd10);
        push_both(4, '0, "r10_cleared");
        tick();

        // Drain the scoreboard.
        w = 0;
        while (due_q.size() > 0 && w < 10) begin
            w++;
            tick();
        end
        checks++;
        if (due_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", due_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ft64_regfile_lvt.md
Name: ft64_regfile_lvt

Overview:
- Parametrised multi-port register file: NW write ports, NR read ports, one RAM bank per write port.
- A live-value table (LVT) records which bank holds the newest copy of each register.
- Adds write-through bypass with fixed one-cycle read latency and a hardware clear sweep after reset.
- Sits in the FT64 register-rename / issue path, feeding operand reads and accepting commit writes.

Parameters:
WID, 64, register data width in bits
AW, 8, register address width; DEPTH = 2**AW
NW, 3, number of write ports (1..4)
NR, 12, number of read ports (1..16)
ZERO_R0, 1, when 1 register 0 reads as zero and writes to it are discarded

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous active-high reset; starts the clear sweep
wr  input  NW  write enable per port
wa  input  NW*AW  write addresses, port p at bits [p*AW +: AW]
i  input  NW*WID  write data, port p at bits [p*WID +: WID]
ra  input  NR*AW  read addresses, port k at bits [k*AW +: AW]
o  output  NR*WID  read data, port k at bits [k*WID +: WID]
busy  output  1  high while the clear sweep runs; writes are ignored while high

Behaviour:
- Single clock domain, single clk.
- rst is synchronous and active-high.
- State machine has two states, CLEAR and RUN.
- Reset:
  - rst sampled high → state CLEAR, sweep counter = 0, busy = 1, all o = 0 on the following cycle.
  - rst held high keeps the counter at 0.
- CLEAR:
  - Each cycle writes 0 to bank 0 at the counter address and sets LVT[counter] = 0, then increments the counter.
  - After the cycle with counter = DEPTH-1, the next state is RUN with busy = 0. The sweep takes exactly DEPTH cycles after rst falls.
  - wr is ignored; every o reads 0.
  - rst asserted mid-sweep restarts the sweep at address 0.
- RUN, writes:
  - Port p with wr[p]=1 writes i_p to bank p at wa_p.
  - LVT[wa_p] = p, except when a higher-numbered enabled port targets the same address. The highest-numbered port always wins on an address collision, for any mix of 2..NW simultaneous writes.
  - Non-colliding writes in the same cycle all commit.
  - Writes to address 0 are dropped when ZERO_R0 = 1.
- RUN, reads:
  - ra_k is registered on the clk edge.
  - o_k in cycle n+1 equals register ra_k(n) after all writes of cycle n are applied (write-through, highest-numbered matching port wins).
  - Otherwise o_k comes from bank LVT[ra_k(n)].
  - ra_k(n) = 0 with ZERO_R0 = 1 returns 0.
  - Read latency is exactly 1 cycle, with no stalls.
- Reads and writes to the same address in one cycle never return stale data; reads to unwritten registers return 0.
- Storage:
  - Banks are block RAM.
  - LVT is a flop array, log2(NW) bits per entry, min 1.
  - Bypass compare logic is NR×NW comparators.
- No X may reach o after the clear sweep.

Test Plan:
- Assert rst 1 cycle, AW=8 → busy high for exactly 256 cycles, then low. Read r5 during the sweep → o=0. Read r5 after the sweep → o=0.
- RUN, wr=3'b001, wa0=10, i0=0x1111 at cycle n; ra0=10 at cycle n → o0=0x1111 at n+1 (bypass). ra0=10 at n+3 → o0=0x1111 (bank 0).
- Same cycle wr=3'b111, wa0=wa1=wa2=20, data 0xA/0xB/0xC → read r20 next and later cycles gives 0xC. Repeat with wr=3'b011 → 0xB.
- wr=3'b111, wa0=wa1=30, wa2=31, data 0x1/0x2/0x3 → r30=0x2, r31=0x3 on all 12 read ports simultaneously.
- ZERO_R0=1: write 0xFFFF to r0 → read r0 returns 0 both same-cycle and later. ZERO_R0=0: read r0 returns 0xFFFF.
- rst re-asserted at sweep cycle 100 after r40=0x55 was written → sweep restarts, busy stays high 256 cycles after rst falls, then r40 reads 0. A wr pulse during busy is discarded.
